// File: rtl/mdu_pkg.sv
// mdu_pkg: funct codes, FSM state encodings and operation kinds shared by the
// multiply/divide unit.
package mdu_pkg;

  // R-type funct field values decoded by the MDU
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MTHI  = 6'd17;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MTLO  = 6'd19;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  // FSM state encodings (IDLE / CALC / FIX)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Kind of iterative operation in flight
  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

endpackage

// File: rtl/mdu_control_if.sv
// mdu_control_if: issue/result bundle between the execute stage (master)
// and the multiply/divide unit (slave).
interface mdu_control_if #(
  parameter int WIDTH = 32
);
  logic             i_con_Start;
  logic [5:0]       i_con_FuncCode;
  logic [WIDTH-1:0] i_dat_A;
  logic [WIDTH-1:0] i_dat_B;
  logic             o_con_Busy;
  logic             o_con_Stall;
  logic [WIDTH-1:0] o_dat_Result;
  logic             o_con_ResultValid;
  logic             o_con_Illegal;
  logic             o_con_DivZero;

  modport master (
    output i_con_Start, i_con_FuncCode, i_dat_A, i_dat_B,
    input  o_con_Busy, o_con_Stall, o_dat_Result, o_con_ResultValid,
           o_con_Illegal, o_con_DivZero
  );

  modport slave (
    input  i_con_Start, i_con_FuncCode, i_dat_A, i_dat_B,
    output o_con_Busy, o_con_Stall, o_dat_Result, o_con_ResultValid,
           o_con_Illegal, o_con_DivZero
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: one-bit-per-cycle datapath. Multiply is a right-shifting
// shift-add into {acc,q}; divide (only when MDU_DIV_EN is defined) is a
// left-shifting restoring subtract leaving remainder in acc, quotient in q.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH-1:0] w_mul_q;

  assign w_sum     = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
  assign w_mul_acc = w_sum[WIDTH:1];
  assign w_mul_q   = {w_sum[0], r_q[WIDTH-1:1]};

`ifdef MDU_DIV_EN
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_div_acc;
  logic [WIDTH-1:0] w_div_q;

  // Partial remainder never exceeds the divisor, so WIDTH+1 bits hold the trial
  assign w_rem_sh  = {r_acc, r_q[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_m};
  assign w_div_acc = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_div_q   = {r_q[WIDTH-2:0], ~w_diff[WIDTH]};

  // Load operands, then advance one multiply or divide step per enabled cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_q   <= '0;
      r_m   <= '0;
    end else if (i_load) begin
      r_acc <= '0;
      r_q   <= i_a;
      r_m   <= i_b;
    end else if (i_step) begin
      if (i_op == OP_DIV) begin
        r_acc <= w_div_acc;
        r_q   <= w_div_q;
      end else begin
        r_acc <= w_mul_acc;
        r_q   <= w_mul_q;
      end
    end
  end
`else
  // Load operands, then advance one multiply step per enabled cycle; a divide
  // kind is never loaded in this build
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_q   <= '0;
      r_m   <= '0;
    end else if (i_load) begin
      r_acc <= '0;
      r_q   <= i_a;
      r_m   <= i_b;
    end else if (i_step && i_op == OP_MUL) begin
      r_acc <= w_mul_acc;
      r_q   <= w_mul_q;
    end
  end
`endif

  assign o_acc = r_acc;
  assign o_q   = r_q;

endmodule

// File: rtl/mdu_control.sv
// mdu_control: funct decode, FSM, iteration counter, sign fix-up and HI/LO.
// Build option: define MDU_DIV_EN to include DIV/DIVU and the divide-by-zero
// flag; otherwise funct 26/27 decode as illegal.
//
//   state | meaning
//   IDLE  | accepts issue; MT*/MF*/div-by-zero/illegal complete here
//   CALC  | WIDTH iteration steps, counter counts down to terminal count
//   FIX   | sign correction, HI/LO written, back to IDLE
module mdu_control
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  mdu_control_if.slave bus
);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  op_e              r_op;
  logic             r_neg_q;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_result;
  logic             r_valid;
  logic             r_illegal;
  logic             r_divzero;

  logic             w_accept;
  logic             w_signed;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_load;
  logic             w_cnt_last;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH-1:0] w_acc;
  logic [WIDTH-1:0] w_q;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;

  assign w_accept = bus.i_con_Start && (r_state == ST_IDLE);
  assign w_is_mul = (bus.i_con_FuncCode == FN_MULT) || (bus.i_con_FuncCode == FN_MULTU);
`ifdef MDU_DIV_EN
  logic r_neg_r;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  assign w_is_div = (bus.i_con_FuncCode == FN_DIV) || (bus.i_con_FuncCode == FN_DIVU);
  assign w_signed = (bus.i_con_FuncCode == FN_MULT) || (bus.i_con_FuncCode == FN_DIV);
  assign w_quo_fix = r_neg_q ? ('0 - w_q) : w_q;
  assign w_rem_fix = r_neg_r ? ('0 - w_acc) : w_acc;
`else
  assign w_is_div = 1'b0;
  assign w_signed = (bus.i_con_FuncCode == FN_MULT);
`endif
  // A zero divisor completes in IDLE, so it must not start the datapath
  assign w_load = w_accept && (w_is_mul || (w_is_div && (bus.i_dat_B != '0)));
  assign w_a_abs = (w_signed && bus.i_dat_A[WIDTH-1]) ? ('0 - bus.i_dat_A) : bus.i_dat_A;
  assign w_b_abs = (w_signed && bus.i_dat_B[WIDTH-1]) ? ('0 - bus.i_dat_B) : bus.i_dat_B;
  assign w_cnt_last = (r_cnt == CNT_W'(1));
  assign w_prod     = {w_acc, w_q};
  assign w_prod_fix = r_neg_q ? ('0 - w_prod) : w_prod;

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_step  (r_state == ST_CALC),
    .i_op    (r_op),
    .i_a     (w_a_abs),
    .i_b     (w_b_abs),
    .o_acc   (w_acc),
    .o_q     (w_q)
  );

  // Decode accepted issue, sequence the iteration and own HI/LO and pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= OP_MUL;
      r_neg_q   <= 1'b0;
`ifdef MDU_DIV_EN
      r_neg_r   <= 1'b0;
`endif
      r_hi      <= '0;
      r_lo      <= '0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_divzero <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          case (bus.i_con_FuncCode)
            FN_MTHI: r_hi <= bus.i_dat_A;
            FN_MTLO: r_lo <= bus.i_dat_A;
            FN_MFHI: begin r_result <= r_hi; r_valid <= 1'b1; end
            FN_MFLO: begin r_result <= r_lo; r_valid <= 1'b1; end
            FN_MULT, FN_MULTU: begin
              r_op    <= OP_MUL;
              r_neg_q <= w_signed && (bus.i_dat_A[WIDTH-1] ^ bus.i_dat_B[WIDTH-1]);
              r_cnt   <= CNT_W'(WIDTH);
              r_state <= ST_CALC;
            end
`ifdef MDU_DIV_EN
            FN_DIV, FN_DIVU: begin
              if (bus.i_dat_B == '0) begin
                r_lo      <= '1;
                r_hi      <= bus.i_dat_A;
                r_divzero <= 1'b1;
              end else begin
                r_op    <= OP_DIV;
                r_neg_q <= w_signed && (bus.i_dat_A[WIDTH-1] ^ bus.i_dat_B[WIDTH-1]);
                r_neg_r <= w_signed && bus.i_dat_A[WIDTH-1];
                r_cnt   <= CNT_W'(WIDTH);
                r_state <= ST_CALC;
              end
            end
`endif
            default: r_illegal <= 1'b1;
          endcase
        end
        ST_CALC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_cnt_last) r_state <= ST_FIX;
        end
        ST_FIX: begin
`ifdef MDU_DIV_EN
          if (r_op == OP_DIV) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
`else
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_fix[WIDTH-1:0];
`endif
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_con_Busy        = (r_state != ST_IDLE);
  assign bus.o_con_Stall       = bus.i_con_Start && (r_state != ST_IDLE);
  assign bus.o_dat_Result      = r_result;
  assign bus.o_con_ResultValid = r_valid;
  assign bus.o_con_Illegal     = r_illegal;
  assign bus.o_con_DivZero     = r_divzero;

endmodule

// File: tb/tb_mdu_control.sv
// tb_mdu_control: directed vectors with hand-computed HI/LO values; checks
// busy length, stall, pulses, divide cases (when MDU_DIV_EN) and async reset.
module tb_mdu_control;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   n;

  mdu_control_if #(.WIDTH(W)) bus ();

  mdu_control #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle issue from IDLE; returns at the negedge after the accepting edge
  task automatic issue(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.i_con_Start    = 1'b1;
    bus.i_con_FuncCode = fn;
    bus.i_dat_A        = a;
    bus.i_dat_B        = b;
    @(negedge clk);
    bus.i_con_Start = 1'b0;
  endtask

  task automatic read_reg(input logic [5:0] fn, input string tag, input logic [W-1:0] exp);
    issue(fn, '0, '0);
    check({tag, "_valid"}, W'(bus.o_con_ResultValid), W'(1));
    check(tag, bus.o_dat_Result, exp);
  endtask

  // Counts busy cycles sampled at negedges, bounded
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.o_con_Busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    bus.i_con_Start    = 1'b0;
    bus.i_con_FuncCode = '0;
    bus.i_dat_A        = '0;
    bus.i_dat_B        = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",    W'(bus.o_con_Busy), W'(0));
    check("rst_stall",   W'(bus.o_con_Stall), W'(0));
    check("rst_valid",   W'(bus.o_con_ResultValid), W'(0));
    check("rst_result",  bus.o_dat_Result, '0);
    check("rst_illegal", W'(bus.o_con_Illegal), W'(0));
    check("rst_divzero", W'(bus.o_con_DivZero), W'(0));
    rst_n = 1'b1;
    read_reg(FN_MFHI, "rst_hi", 32'h0);
    read_reg(FN_MFLO, "rst_lo", 32'h0);

    // MULT -1 * 2
    issue(FN_MULT, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    check("mult_busy_len", W'(n), W'(33));
    read_reg(FN_MFHI, "mult_hi", 32'hFFFF_FFFF);
    read_reg(FN_MFLO, "mult_lo", 32'hFFFF_FFFE);

    // MULTU 0xFFFFFFFF * 2
    issue(FN_MULTU, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    check("multu_busy_len", W'(n), W'(33));
    read_reg(FN_MFHI, "multu_hi", 32'h0000_0001);
    read_reg(FN_MFLO, "multu_lo", 32'hFFFF_FFFE);

    // MULT negative * positive with a non-trivial magnitude
    issue(FN_MULT, 32'hFFFF_FFFD, 32'd5);
    count_busy(n);
    read_reg(FN_MFHI, "mult_neg_hi", 32'hFFFF_FFFF);
    read_reg(FN_MFLO, "mult_neg_lo", 32'hFFFF_FFF1);

`ifdef MDU_DIV_EN
    issue(FN_DIV, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    check("div_busy_len", W'(n), W'(33));
    read_reg(FN_MFLO, "div_lo", 32'hFFFF_FFFD);
    read_reg(FN_MFHI, "div_hi", 32'hFFFF_FFFF);

    issue(FN_DIVU, 32'd7, 32'd2);
    count_busy(n);
    read_reg(FN_MFLO, "divu_lo", 32'd3);
    read_reg(FN_MFHI, "divu_hi", 32'd1);

    issue(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    read_reg(FN_MFLO, "divmin_lo", 32'h8000_0000);
    read_reg(FN_MFHI, "divmin_hi", 32'h0);

    issue(FN_DIVU, 32'h0000_1234, 32'd0);
    check("dz_pulse", W'(bus.o_con_DivZero), W'(1));
    check("dz_busy",  W'(bus.o_con_Busy), W'(0));
    @(negedge clk);
    check("dz_pulse_end", W'(bus.o_con_DivZero), W'(0));
    read_reg(FN_MFLO, "dz_lo", 32'hFFFF_FFFF);
    read_reg(FN_MFHI, "dz_hi", 32'h0000_1234);
`else
    issue(FN_DIV, 32'hFFFF_FFF9, 32'd2);
    check("nodiv_illegal", W'(bus.o_con_Illegal), W'(1));
    check("nodiv_busy",    W'(bus.o_con_Busy), W'(0));
    issue(FN_DIVU, 32'h0000_1234, 32'd0);
    check("nodiv_illegal_z", W'(bus.o_con_Illegal), W'(1));
    check("nodiv_divzero",   W'(bus.o_con_DivZero), W'(0));
    read_reg(FN_MFLO, "nodiv_lo", 32'hFFFF_FFF1);
`endif

    // MULT, then MFLO held on Start until accepted
    issue(FN_MULT, 32'h0001_2345, 32'h0000_0100);
    bus.i_con_Start    = 1'b1;
    bus.i_con_FuncCode = FN_MFLO;
    n = 0;
    while (bus.o_con_Stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("stall_len", W'(n), W'(33));
    @(negedge clk);
    bus.i_con_Start = 1'b0;
    check("stall_valid",  W'(bus.o_con_ResultValid), W'(1));
    check("stall_result", bus.o_dat_Result, 32'h0123_4500);
    @(negedge clk);
    check("valid_pulse_end", W'(bus.o_con_ResultValid), W'(0));

    // MTHI then MFHI back to back; MTLO then MFLO
    issue(FN_MTHI, 32'hA5A5_A5A5, '0);
    read_reg(FN_MFHI, "mthi_mfhi", 32'hA5A5_A5A5);
    issue(FN_MTLO, 32'h5A5A_0F0F, '0);
    read_reg(FN_MFLO, "mtlo_mflo", 32'h5A5A_0F0F);

    // Unsupported funct
    issue(6'd20, '0, '0);
    check("illegal_pulse", W'(bus.o_con_Illegal), W'(1));
    check("illegal_busy",  W'(bus.o_con_Busy), W'(0));
    @(negedge clk);
    check("illegal_pulse_end", W'(bus.o_con_Illegal), W'(0));

    // Async reset in the middle of CALC
    issue(FN_MULT, 32'hFFFF_FFFF, 32'd2);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", W'(bus.o_con_Busy), W'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   W'(bus.o_con_Busy), W'(0));
    check("midrst_result", bus.o_dat_Result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    read_reg(FN_MFHI, "midrst_hi", 32'h0);
    read_reg(FN_MFLO, "midrst_lo", 32'h0);
    issue(FN_MULT, 32'd3, 32'd4);
    count_busy(n);
    check("post_rst_busy_len", W'(n), W'(33));
    read_reg(FN_MFLO, "post_rst_lo", 32'd12);
    read_reg(FN_MFHI, "post_rst_hi", 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
